// File: rtl/calc_pkg.sv
// Shared key codes, operator/state encodings and width helpers for the keypad calculator core.
package calc_pkg;

    localparam logic [7:0] KEY_ADD  = 8'hF0;
    localparam logic [7:0] KEY_SUB  = 8'hF1;
    localparam logic [7:0] KEY_MUL  = 8'hF2;
    localparam logic [7:0] KEY_EQU  = 8'hF3;
    localparam logic [7:0] KEY_CLR  = 8'hC0;
    localparam logic [7:0] KEY_BKSP = 8'hB0;

    typedef enum logic [1:0] {
        OP_ADD = 2'd0,
        OP_SUB = 2'd1,
        OP_MUL = 2'd2
    } op_e;

    typedef enum logic [3:0] {
        S_IDLE, S_A, S_OP, S_B, S_CVT, S_ALU, S_B2D, S_RES, S_ERR
    } state_e;

    function automatic longint pow10(input int n);
        longint p;
        p = 1;
        for (int i = 0; i < n; i++) p = p * 10;
        return p;
    endfunction

    // Signed result width: magnitude bits for a full-width product plus a sign bit.
    function automatic int calc_rw(input int digits);
        return $clog2(pow10(2 * digits)) + 1;
    endfunction

endpackage

// File: rtl/calc_seq_core_bin2bcd_seq.sv
// Serial double-dabble converter: one input bit per cycle, start/done handshake, sync abort.
module bin2bcd_seq #(
    parameter int W  = 14,
    parameter int ND = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clr_i,
    input  logic            start_i,
    input  logic [W-1:0]    bin_i,
    output logic            done_o,
    output logic [4*ND-1:0] bcd_o
);
    localparam int CNT_W = $clog2(W + 1);

    logic [CNT_W-1:0] cnt_q;
    logic             run_q;
    logic             done_q;
    logic [W-1:0]     sh_q;
    logic [4*ND-1:0]  bcd_q;

    function automatic logic [4*ND-1:0] add3(input logic [4*ND-1:0] v);
        logic [4*ND-1:0] r;
        r = v;
        for (int i = 0; i < ND; i++) begin
            if (v[4*i +: 4] >= 4'd5) r[4*i +: 4] = v[4*i +: 4] + 4'd3;
        end
        return r;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            run_q  <= 1'b0;
            done_q <= 1'b0;
            cnt_q  <= '0;
        end else if (clr_i) begin
            run_q  <= 1'b0;
            done_q <= 1'b0;
        end else if (start_i) begin
            run_q  <= 1'b1;
            done_q <= 1'b0;
            cnt_q  <= CNT_W'(W);
        end else if (run_q) begin
            cnt_q <= cnt_q - 1'b1;
            if (cnt_q == CNT_W'(1)) begin
                run_q  <= 1'b0;
                done_q <= 1'b1;
            end
        end
    end

    // Datapath carries no reset; it is reloaded on every start.
    always_ff @(posedge clk) begin
        if (start_i) begin
            sh_q  <= bin_i;
            bcd_q <= '0;
        end else if (run_q) begin
            {bcd_q, sh_q} <= {add3(bcd_q), sh_q} << 1;
        end
    end

    assign done_o = done_q;
    assign bcd_o  = bcd_q;

endmodule

// File: rtl/calc_seq_core.sv
// Keypad calculator core: BCD operand entry, binary ALU, serial BCD result with sign/overflow.
// Optional backspace key support is compiled in with CALC_BACKSPACE_EN.
module calc_seq_core
    import calc_pkg::*;
#(
    parameter int DIGITS = 2,
    parameter int DISP   = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              key_valid,
    input  logic [7:0]        key_code,
    output logic [4*DISP-1:0] disp_bcd,
    output logic [DISP-1:0]   disp_blank,
    output logic              neg,
    output logic              err,
    output logic              busy,
    output logic              result_valid
);
    localparam int RW = calc_rw(DIGITS);
    localparam int MW = RW - 1;
    localparam int OW = 4 * DIGITS;
    localparam int CW = $clog2(DIGITS + 1);
    localparam logic [63:0] LIMIT = 64'(pow10(DISP));

    state_e         state_q, state_d;
    op_e            op_q, op_d;
    logic [OW-1:0]  a_q, a_d, b_q, b_d;
    logic [CW-1:0]  na_q, na_d, nb_q, nb_d, cvt_q, cvt_d;
    logic [MW-1:0]  acc_a_q, acc_a_d, acc_b_q, acc_b_d;
    logic           neg_q, neg_d;

    logic                  is_digit, is_op, is_equ, is_clr;
    logic signed [RW-1:0]  opa_s, opb_s, res_s;
    logic [MW-1:0]         mag;
    logic                  ovf;
    logic                  b2d_start, b2d_clr, b2d_done;
    logic [4*DISP-1:0]     b2d_bcd;

    assign is_digit = key_valid && (key_code <= 8'h09);
    assign is_op    = key_valid && (key_code == KEY_ADD || key_code == KEY_SUB || key_code == KEY_MUL);
    assign is_equ   = key_valid && (key_code == KEY_EQU);
    assign is_clr   = key_valid && (key_code == KEY_CLR);
`ifdef CALC_BACKSPACE_EN
    logic is_bksp;
    assign is_bksp  = key_valid && (key_code == KEY_BKSP);
`endif

    function automatic op_e key_op(input logic [7:0] c);
        case (c)
            KEY_SUB: return OP_SUB;
            KEY_MUL: return OP_MUL;
            default: return OP_ADD;
        endcase
    endfunction

    function automatic logic [MW-1:0] times10(input logic [MW-1:0] v);
        return (v << 3) + (v << 1);
    endfunction

    function automatic logic [MW-1:0] abs_mag(input logic signed [RW-1:0] v);
        logic signed [RW-1:0] a;
        a = v[RW-1] ? -v : v;
        return a[MW-1:0];
    endfunction

    function automatic logic [DISP-1:0] entry_blank(input logic [CW-1:0] n);
        logic [DISP-1:0] m;
        for (int i = 0; i < DISP; i++) m[i] = (i != 0) && (i >= int'(n));
        return m;
    endfunction

    function automatic logic [DISP-1:0] result_blank(input logic [4*DISP-1:0] v);
        logic [DISP-1:0] m;
        logic            seen;
        m    = '0;
        seen = 1'b0;
        for (int i = DISP - 1; i > 0; i--) begin
            if (v[4*i +: 4] != 4'd0) seen = 1'b1;
            m[i] = !seen;
        end
        return m;
    endfunction

    // ALU stage: operands are non-negative, so zero-extension gives their signed form.
    always_comb begin
        opa_s = signed'({1'b0, acc_a_q});
        opb_s = signed'({1'b0, acc_b_q});
        case (op_q)
            OP_SUB:  res_s = opa_s - opb_s;
            OP_MUL:  res_s = opa_s * opb_s;
            default: res_s = opa_s + opb_s;
        endcase
        mag = abs_mag(res_s);
        ovf = 64'(mag) >= LIMIT;
    end

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        a_d       = a_q;
        b_d       = b_q;
        na_d      = na_q;
        nb_d      = nb_q;
        cvt_d     = cvt_q;
        acc_a_d   = acc_a_q;
        acc_b_d   = acc_b_q;
        neg_d     = neg_q;
        b2d_start = 1'b0;
        b2d_clr   = 1'b0;
        if (is_clr) begin
            state_d = S_IDLE;
            a_d     = '0;
            b_d     = '0;
            na_d    = '0;
            nb_d    = '0;
            b2d_clr = 1'b1;
        end else begin
            case (state_q)
                S_IDLE, S_RES: begin
                    if (is_digit) begin
                        state_d = S_A;
                        a_d     = OW'(key_code[3:0]);
                        na_d    = CW'(1);
                    end else if (is_op) begin
                        state_d = S_OP;
                        op_d    = key_op(key_code);
                        a_d     = '0;
                        na_d    = '0;
                        b_d     = '0;
                        nb_d    = '0;
                    end
                end
                S_A: begin
                    if (is_digit) begin
                        if (na_q != CW'(DIGITS)) begin
                            a_d  = (a_q << 4) | OW'(key_code[3:0]);
                            na_d = na_q + 1'b1;
                        end
                    end else if (is_op) begin
                        state_d = S_OP;
                        op_d    = key_op(key_code);
                        b_d     = '0;
                        nb_d    = '0;
`ifdef CALC_BACKSPACE_EN
                    end else if (is_bksp) begin
                        a_d  = a_q >> 4;
                        na_d = na_q - 1'b1;
                        if (na_q == CW'(1)) state_d = S_IDLE;
`endif
                    end
                end
                S_OP: begin
                    if (is_digit) begin
                        state_d = S_B;
                        b_d     = OW'(key_code[3:0]);
                        nb_d    = CW'(1);
                    end else if (is_op) begin
                        op_d = key_op(key_code);
                    end else if (is_equ) begin
                        state_d = S_CVT;
                        b_d     = '0;
                        nb_d    = '0;
                        cvt_d   = CW'(DIGITS - 1);
                        acc_a_d = '0;
                        acc_b_d = '0;
                    end
                end
                S_B: begin
                    if (is_digit) begin
                        if (nb_q != CW'(DIGITS)) begin
                            b_d  = (b_q << 4) | OW'(key_code[3:0]);
                            nb_d = nb_q + 1'b1;
                        end
                    end else if (is_equ) begin
                        state_d = S_CVT;
                        cvt_d   = CW'(DIGITS - 1);
                        acc_a_d = '0;
                        acc_b_d = '0;
`ifdef CALC_BACKSPACE_EN
                    end else if (is_bksp) begin
                        b_d  = b_q >> 4;
                        nb_d = nb_q - 1'b1;
                        if (nb_q == CW'(1)) state_d = S_OP;
`endif
                    end
                end
                // Both operands convert together, most significant digit first.
                S_CVT: begin
                    acc_a_d = times10(acc_a_q) + MW'(a_q[4*cvt_q +: 4]);
                    acc_b_d = times10(acc_b_q) + MW'(b_q[4*cvt_q +: 4]);
                    cvt_d   = cvt_q - 1'b1;
                    if (cvt_q == '0) state_d = S_ALU;
                end
                S_ALU: begin
                    neg_d = res_s < 0;
                    if (ovf) begin
                        state_d = S_ERR;
                    end else begin
                        state_d   = S_B2D;
                        b2d_start = 1'b1;
                    end
                end
                S_B2D: if (b2d_done) state_d = S_RES;
                S_ERR: ;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            op_q    <= OP_ADD;
            na_q    <= '0;
            nb_q    <= '0;
            cvt_q   <= '0;
            neg_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            na_q    <= na_d;
            nb_q    <= nb_d;
            cvt_q   <= cvt_d;
            neg_q   <= neg_d;
        end
    end

    always_ff @(posedge clk) begin
        a_q     <= a_d;
        b_q     <= b_d;
        acc_a_q <= acc_a_d;
        acc_b_q <= acc_b_d;
    end

    bin2bcd_seq #(.W(MW), .ND(DISP)) u_b2d (
        .clk     (clk),
        .rst     (rst),
        .clr_i   (b2d_clr),
        .start_i (b2d_start),
        .bin_i   (mag),
        .done_o  (b2d_done),
        .bcd_o   (b2d_bcd)
    );

    always_comb begin
        disp_bcd   = '0;
        disp_blank = entry_blank('0);
        case (state_q)
            S_A, S_OP: begin
                disp_bcd   = (4*DISP)'(a_q);
                disp_blank = entry_blank(na_q);
            end
            S_B, S_CVT, S_ALU, S_B2D: begin
                disp_bcd   = (4*DISP)'(b_q);
                disp_blank = entry_blank(nb_q);
            end
            S_RES: begin
                disp_bcd   = b2d_bcd;
                disp_blank = result_blank(b2d_bcd);
            end
            S_ERR:   disp_blank = '1;
            default: ;
        endcase
    end

    assign busy         = (state_q == S_CVT) || (state_q == S_ALU) || (state_q == S_B2D);
    assign result_valid = (state_q == S_RES);
    assign err          = (state_q == S_ERR);
    assign neg          = result_valid && neg_q;

endmodule

// File: tb/tb_calc_seq_core.sv
// Scoreboard bench for calc_seq_core: DIGITS=2 with DISP=4 and DISP=3 instances on shared keys.
module tb_calc_seq_core;

    localparam logic [7:0] K_ADD = 8'hF0, K_SUB = 8'hF1, K_MUL = 8'hF2;
    localparam logic [7:0] K_EQU = 8'hF3, K_CLR = 8'hC0, K_BKSP = 8'hB0;
    // 10^4 = 10000 needs 14 bits, plus sign: RW = 15; latency = DIGITS + RW + 1.
    localparam int LAT = 2 + 15 + 1;

    logic        clk = 1'b0;
    logic        rst;
    logic        key_valid;
    logic [7:0]  key_code;
    logic [15:0] disp_bcd;
    logic [3:0]  disp_blank;
    logic        neg, err, busy, result_valid;
    logic [11:0] d3_bcd;
    logic [2:0]  d3_blank;
    logic        d3_neg, d3_err, d3_busy, d3_rv;

    int n_cmp = 0;
    int n_fail = 0;
    int cyc = 0;

    typedef struct {
        logic [15:0] bcd;
        logic [3:0]  blank;
        logic        neg;
        logic        err;
    } exp_t;

    exp_t sb4[$];
    exp_t sb3[$];

    int ta[6]   = '{12, 5, 3, 7, 0, 99};
    int tand[6] = '{2, 1, 1, 1, 0, 2};
    int top[6]  = '{0, 1, 1, 0, 1, 2};
    int tb[6]   = '{34, 73, 3, 0, 25, 99};
    int tbnd[6] = '{2, 2, 1, 0, 2, 2};
    bit tpoke[6] = '{0, 1, 0, 0, 0, 0};

    calc_seq_core #(.DIGITS(2), .DISP(4)) dut (
        .clk(clk), .rst(rst), .key_valid(key_valid), .key_code(key_code),
        .disp_bcd(disp_bcd), .disp_blank(disp_blank), .neg(neg), .err(err),
        .busy(busy), .result_valid(result_valid)
    );

    calc_seq_core #(.DIGITS(2), .DISP(3)) dut3 (
        .clk(clk), .rst(rst), .key_valid(key_valid), .key_code(key_code),
        .disp_bcd(d3_bcd), .disp_blank(d3_blank), .neg(d3_neg), .err(d3_err),
        .busy(d3_busy), .result_valid(d3_rv)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int p10(input int n);
        int p;
        p = 1;
        for (int i = 0; i < n; i++) p = p * 10;
        return p;
    endfunction

    function automatic exp_t model(input int a, input int b, input int op, input int disp);
        exp_t e;
        int r, m;
        r = (op == 0) ? a + b : (op == 1) ? a - b : a * b;
        m = (r < 0) ? -r : r;
        e.err = (m >= p10(disp));
        e.neg = (r < 0) && !e.err;
        e.bcd = '0;
        e.blank = '1;
        if (!e.err) begin
            for (int i = 0; i < 4; i++) e.bcd[4*i +: 4] = 4'((m / p10(i)) % 10);
            for (int i = 0; i < 4; i++) e.blank[i] = (i > 0) && (m < p10(i));
        end
        return e;
    endfunction

    task automatic press(input logic [7:0] c);
        key_code  = c;
        key_valid = 1'b1;
        @(negedge clk);
        key_valid = 1'b0;
    endtask

    task automatic enter(input int v, input int nd);
        for (int i = nd - 1; i >= 0; i--) press(8'((v / p10(i)) % 10));
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({disp_bcd, disp_blank, neg, err, busy, result_valid} !== {16'h0, 4'b1110, 4'b0000}) begin
            n_fail++;
            $display("FAIL reset_dut4: got %h want %h", {disp_bcd, disp_blank, neg, err, busy, result_valid}, {16'h0, 4'b1110, 4'b0000});
        end
        n_cmp++;
        if ({d3_bcd, d3_blank, d3_neg, d3_err, d3_busy, d3_rv} !== {12'h0, 3'b110, 4'b0000}) begin
            n_fail++;
            $display("FAIL reset_dut3: got %h want %h", {d3_bcd, d3_blank, d3_neg, d3_err, d3_busy, d3_rv}, {12'h0, 3'b110, 4'b0000});
        end
        rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({disp_bcd, disp_blank, busy, result_valid} !== {16'h0, 4'b1110, 2'b00}) begin
            n_fail++;
            $display("FAIL reset_release: got %h want %h", {disp_bcd, disp_blank, busy, result_valid}, {16'h0, 4'b1110, 2'b00});
        end
    endtask

    task automatic test_entry();
        logic [19:0] want;
        press(K_CLR);
        enter(12, 2);
        n_cmp++;
        if ({disp_bcd, disp_blank} !== {16'h0012, 4'b1100}) begin
            n_fail++;
            $display("FAIL entry_12: got %h want %h", {disp_bcd, disp_blank}, {16'h0012, 4'b1100});
        end
        press(8'h03);
        n_cmp++;
        if ({disp_bcd, disp_blank} !== {16'h0012, 4'b1100}) begin
            n_fail++;
            $display("FAIL entry_full: got %h want %h", {disp_bcd, disp_blank}, {16'h0012, 4'b1100});
        end
        press(K_CLR);
        press(8'h01); press(8'h02); press(K_BKSP); press(8'h07);
`ifdef CALC_BACKSPACE_EN
        want = {16'h0017, 4'b1100};
`else
        want = {16'h0012, 4'b1100};
`endif
        n_cmp++;
        if ({disp_bcd, disp_blank} !== want) begin
            n_fail++;
            $display("FAIL bksp_edit: got %h want %h", {disp_bcd, disp_blank}, want);
        end
        press(K_BKSP); press(K_BKSP);
`ifdef CALC_BACKSPACE_EN
        want = {16'h0000, 4'b1110};
`else
        want = {16'h0012, 4'b1100};
`endif
        n_cmp++;
        if ({disp_bcd, disp_blank} !== want) begin
            n_fail++;
            $display("FAIL bksp_empty: got %h want %h", {disp_bcd, disp_blank}, want);
        end
        press(K_CLR);
    endtask

    task automatic test_arith();
        exp_t e4, e3;
        int t_eq;
        for (int i = 0; i < 6; i++) begin
            enter(ta[i], tand[i]);
            press((top[i] == 0) ? K_ADD : (top[i] == 1) ? K_SUB : K_MUL);
            enter(tb[i], tbnd[i]);
            press(K_EQU);
            t_eq = cyc;
            sb4.push_back(model(ta[i], tb[i], top[i], 4));
            sb3.push_back(model(ta[i], tb[i], top[i], 3));
            n_cmp++;
            if (busy !== 1'b1) begin
                n_fail++;
                $display("FAIL busy_rise case %0d: got %b want 1", i, busy);
            end
            while (!(result_valid || err) && (cyc - t_eq) < 60) begin
                key_valid = tpoke[i] && ((cyc - t_eq) == 5);
                key_code  = 8'h08;
                @(negedge clk);
            end
            key_valid = 1'b0;
            e4 = sb4.pop_front();
            e3 = sb3.pop_front();
            n_cmp++;
            if ((cyc - t_eq) !== LAT) begin
                n_fail++;
                $display("FAIL latency case %0d: got %0d want %0d", i, cyc - t_eq, LAT);
            end
            n_cmp++;
            if ({disp_bcd, disp_blank, neg, err, result_valid, busy} !== {e4.bcd, e4.blank, e4.neg, e4.err, !e4.err, 1'b0}) begin
                n_fail++;
                $display("FAIL result4 case %0d: got %h want %h", i,
                         {disp_bcd, disp_blank, neg, err, result_valid, busy}, {e4.bcd, e4.blank, e4.neg, e4.err, !e4.err, 1'b0});
            end
            n_cmp++;
            if ({d3_bcd, d3_blank, d3_neg, d3_err, d3_rv} !== {e3.bcd[11:0], e3.blank[2:0], e3.neg, e3.err, !e3.err}) begin
                n_fail++;
                $display("FAIL result3 case %0d: got %h want %h", i,
                         {d3_bcd, d3_blank, d3_neg, d3_err, d3_rv}, {e3.bcd[11:0], e3.blank[2:0], e3.neg, e3.err, !e3.err});
            end
        end
    endtask

    task automatic test_overflow_clear();
        press(8'h05);
        n_cmp++;
        if ({d3_err, d3_blank} !== {1'b1, 3'b111}) begin
            n_fail++;
            $display("FAIL err_sticky: got %h want %h", {d3_err, d3_blank}, {1'b1, 3'b111});
        end
        press(K_CLR);
        n_cmp++;
        if ({d3_bcd, d3_blank, d3_err, d3_rv} !== {12'h0, 3'b110, 2'b00}) begin
            n_fail++;
            $display("FAIL err_clear: got %h want %h", {d3_bcd, d3_blank, d3_err, d3_rv}, {12'h0, 3'b110, 2'b00});
        end
    endtask

    task automatic test_clear_abort();
        bit seen_rv;
        press(8'h04); press(K_ADD); press(8'h04); press(K_EQU);
        @(negedge clk);
        press(K_CLR);
        n_cmp++;
        if ({busy, result_valid, disp_bcd, disp_blank} !== {2'b00, 16'h0, 4'b1110}) begin
            n_fail++;
            $display("FAIL clear_abort: got %h want %h", {busy, result_valid, disp_bcd, disp_blank}, {2'b00, 16'h0, 4'b1110});
        end
        seen_rv = 1'b0;
        repeat (30) begin
            @(negedge clk);
            if (result_valid) seen_rv = 1'b1;
        end
        n_cmp++;
        if (seen_rv !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_no_result: got %b want 0", seen_rv);
        end
    endtask

    task automatic test_rst_mid();
        press(8'h04); press(K_ADD); press(8'h04); press(K_EQU);
        repeat (10) @(negedge clk);
        n_cmp++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL busy_mid: got %b want 1", busy);
        end
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if ({disp_bcd, disp_blank, neg, err, busy, result_valid} !== {16'h0, 4'b1110, 4'b0000}) begin
            n_fail++;
            $display("FAIL rst_async: got %h want %h", {disp_bcd, disp_blank, neg, err, busy, result_valid}, {16'h0, 4'b1110, 4'b0000});
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (25) @(negedge clk);
        n_cmp++;
        if ({busy, result_valid, disp_blank} !== {2'b00, 4'b1110}) begin
            n_fail++;
            $display("FAIL rst_after: got %h want %h", {busy, result_valid, disp_blank}, {2'b00, 4'b1110});
        end
    endtask

    initial begin
        rst       = 1'b1;
        key_valid = 1'b0;
        key_code  = 8'h00;
        test_reset();
        test_entry();
        test_arith();
        test_overflow_clear();
        test_clear_abort();
        test_rst_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
